wave_timing_monitor: RTL and testbench
======================================

WAVE_TIMING_MONITOR -- requirements
Module: wave_timing_monitor

Interface
REQ-001 Parameter: EXP_F_LOW, 199, expected cycles per period with f low.
REQ-002 Parameter: EXP_G_HIGH, 249, expected cycles per period with g high.
REQ-003 Parameter: EXP_PERIOD, 901, expected cycles between consecutive f falling edges.
REQ-004 Parameter: TOL, 0, allowed absolute deviation for every check.
REQ-005 Port: clock  in  1  sole clock; all state updates on rising edge.
REQ-006 Port: resetn  in  1  reset, asynchronous, active-low.
REQ-007 Port: f_in  in  1  monitored waveform f, synchronous to clock.
REQ-008 Port: g_in  in  1  monitored waveform g, synchronous to clock.
REQ-009 Port: meas_ready  in  1  consumer accepts result when high with meas_valid.
REQ-010 Port: meas_valid  out  1  result registers hold an unconsumed measurement.
REQ-011 Port: f_low_len, g_high_len, period_len, phase_len  out  10 each  measured counts.
REQ-012 Port: err_f, err_g, err_p  out  1 each  check failures for the held result.
REQ-013 Port: overrun, timeout  out  1 each  sticky status flags.
REQ-014 Port: locked  out  1  monitor tracking a conforming waveform.

Function
REQ-015 f falling edge (fall_f) SHALL be flagged in a cycle where previous-cycle f was 1 and f_in is 0; g rising edge (rise_g) likewise for 0 to 1 on g_in.
REQ-016 State machine SHALL have states SEARCH and MEAS; reset enters SEARCH.
REQ-017 SEARCH: counters idle; on fall_f -> MEAS, with period_cnt=1, f_low_cnt=1, g_high_cnt=g_in, phase_cnt=1.
REQ-018 MEAS, non-fall cycles: period_cnt +1; f_low_cnt +1 when f_in=0; g_high_cnt +1 when g_in=1; phase_cnt +1 until first rise_g of the period, then frozen.
REQ-019 MEAS on fall_f: current counts SHALL be published, then counters reload per REQ-017 in the same cycle; state stays MEAS.
REQ-020 All counters 10-bit, saturating at 1023, never wrapping.
REQ-021 Publish: results and err_* registered; meas_valid high the cycle after the fall_f cycle (latency 1).
REQ-022 err_f=1 iff |f_low_len-EXP_F_LOW|>TOL; err_g, err_p likewise against EXP_G_HIGH, EXP_PERIOD.
REQ-023 Handshake: meas_valid&meas_ready in a cycle consumes result; meas_valid falls next cycle unless a publish coincides, in which case the new result loads and meas_valid stays 1.
REQ-024 Publish while meas_valid=1 and meas_ready=0: new result dropped, held result unchanged, overrun set sticky.
REQ-025 period_cnt reaching 1023 in MEAS: -> SEARCH, timeout set sticky, locked cleared, no publish.
REQ-026 locked SHALL set after two consecutive publishes with all err_*=0 (dropped results still count) and clear on any publish with an error or on timeout.
REQ-027 overrun and timeout SHALL clear only on reset.

Reset
REQ-028 resetn low SHALL immediately force: state SEARCH, all counters 0, meas_valid=0, all *_len=0, err_*=0, overrun=0, timeout=0, locked=0, edge-history registers 0.
REQ-029 Reset mid-period SHALL discard the partial measurement; first publish requires two fall_f after release.

Configuration
REQ-030 Macro WAVE_MON_PHASE_EN defined: phase_len reports cycles from fall_f to first rise_g (expected 100), added to checks with err_p also set when |phase_len-100|>TOL.
REQ-031 Macro undefined: phase counter absent, phase_len constant 0, err_p covers period only.

Verification
REQ-032 Reference waveform (f low counts 51..249, g high 151..399, period 901), meas_ready=1 -> each publish 199/249/901 (phase 100 if enabled), err_*=0, locked=1 after second publish.
REQ-033 Same waveform, meas_ready=0 for two periods -> first result held, overrun=1, released values still 199/249/901.
REQ-034 f low stretched to 210 cycles in one period, TOL=0 -> err_f=1 on that result, locked=0, relocks after two clean periods.
REQ-035 f held high 1100 cycles after lock -> timeout=1 at period_cnt 1023, locked=0, state SEARCH, no publish.
REQ-036 resetn pulsed low mid-period -> all outputs 0 same cycle; first meas_valid after second fall_f following release.
REQ-037 meas_ready=1 coinciding with a publish cycle -> meas_valid stays 1, new values loaded, overrun stays 0.

Source files
------------

// File: rtl/wave_timing_monitor.sv
// -----------------------------------------------------------------------------
// wave_timing_monitor
//
// Measures the timing of two related waveforms, f and g, once per f period.
// A period runs from one falling edge of f to the next. Over each period the
// block counts the period length, the number of cycles f is low and the number
// of cycles g is high. At every f falling edge the finished counts are
// published, together with pass/fail flags against the expected values, and
// the counters restart for the new period.
//
// Optional feature (macro WAVE_MON_PHASE_EN):
//   defined   - also measures the phase from the f falling edge to the first
//               g rising edge of the period (expected 100 cycles); a phase
//               outside tolerance also raises err_p.
//   undefined - no phase counter; phase_len is constant 0 and err_p covers
//               the period only.
//
// Ports
//   clock        in   sole clock, rising edge
//   resetn       in   asynchronous active-low reset
//   f_in, g_in   in   monitored waveforms, synchronous to clock
//   meas_ready   in   consumer accepts the held result when meas_valid is high
//   meas_valid   out  result registers hold an unconsumed measurement
//   f_low_len    out  cycles f was low in the measured period
//   g_high_len   out  cycles g was high in the measured period
//   period_len   out  cycles between the two bounding f falling edges
//   phase_len    out  cycles from f falling edge to first g rising edge
//   err_f/g/p    out  tolerance failures for the held result
//   overrun      out  sticky: a result was dropped because the last was unread
//   timeout      out  sticky: no f falling edge within 1022 cycles
//   locked       out  two or more consecutive clean results seen
// -----------------------------------------------------------------------------
module wave_timing_monitor #(
    parameter int EXP_F_LOW  = 199,
    parameter int EXP_G_HIGH = 249,
    parameter int EXP_PERIOD = 901,
    parameter int TOL        = 0
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       f_in,
    input  logic       g_in,
    input  logic       meas_ready,
    output logic       meas_valid,
    output logic [9:0] f_low_len,
    output logic [9:0] g_high_len,
    output logic [9:0] period_len,
    output logic [9:0] phase_len,
    output logic       err_f,
    output logic       err_g,
    output logic       err_p,
    output logic       overrun,
    output logic       timeout,
    output logic       locked
);

    localparam logic [9:0] CNT_MAX = 10'd1023;

    typedef enum logic {
        SEARCH = 1'b0,
        MEAS   = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic       r_f_prev;
    logic       w_fall_f;

    logic [9:0] r_period_cnt;
    logic [9:0] r_f_low_cnt;
    logic [9:0] r_g_high_cnt;

    logic       w_reload;
    logic       w_publish;
    logic       w_timeout_evt;

    logic       w_err_f;
    logic       w_err_g;
    logic       w_err_p;
    logic       w_any_err;

    logic       r_meas_valid;
    logic [9:0] r_f_low_len;
    logic [9:0] r_g_high_len;
    logic [9:0] r_period_len;
    logic       r_err_f;
    logic       r_err_g;
    logic       r_err_p;
    logic       r_overrun;
    logic       r_timeout;
    logic       r_locked;
    logic       r_last_clean;

    // Counters stick at full scale rather than wrapping.
    function automatic logic [9:0] sat_inc(input logic [9:0] v, input logic en);
        return (en && (v != CNT_MAX)) ? v + 10'd1 : v;
    endfunction

    function automatic logic out_of_tol(input logic [9:0] meas, input int exp_val);
        int diff;
        diff = int'({22'd0, meas}) - exp_val;
        if (diff < 0) diff = -diff;
        return diff > TOL;
    endfunction

    assign w_fall_f = r_f_prev & ~f_in;

`ifdef WAVE_MON_PHASE_EN
    localparam int EXP_PHASE = 100;

    logic       r_g_prev;
    logic       w_rise_g;
    logic [9:0] r_phase_cnt;
    logic       r_phase_done;
    logic [9:0] r_phase_len;

    assign w_rise_g = ~r_g_prev & g_in;
`endif

    // -------------------------------------------------------------------------
    // Edge history
    // -------------------------------------------------------------------------
    // NOTE: every register in this block is updated with non-blocking
    // assignments so that all flops sample the pre-edge values together.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_f_prev <= 1'b0;
`ifdef WAVE_MON_PHASE_EN
            r_g_prev <= 1'b0;
`endif
        end else begin
            r_f_prev <= f_in;
`ifdef WAVE_MON_PHASE_EN
            r_g_prev <= g_in;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // State machine
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= SEARCH;
        else         r_state <= w_state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt   = r_state;
        w_reload      = 1'b0;
        w_publish     = 1'b0;
        w_timeout_evt = 1'b0;
        case (r_state)
            SEARCH: begin
                if (w_fall_f) begin
                    w_state_nxt = MEAS;
                    w_reload    = 1'b1;
                end
            end
            MEAS: begin
                if (w_fall_f) begin
                    w_publish = 1'b1;
                    w_reload  = 1'b1;
                end else if (r_period_cnt == CNT_MAX - 10'd1) begin
                    // This edge would take the period count to full scale.
                    w_state_nxt   = SEARCH;
                    w_timeout_evt = 1'b1;
                end
            end
            default: w_state_nxt = SEARCH;
        endcase
    end

    // -------------------------------------------------------------------------
    // Period counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_period_cnt <= '0;
            r_f_low_cnt  <= '0;
            r_g_high_cnt <= '0;
        end else if (w_reload) begin
            // The falling-edge cycle is the first cycle of the new period.
            r_period_cnt <= 10'd1;
            r_f_low_cnt  <= 10'd1;
            r_g_high_cnt <= {9'd0, g_in};
        end else if ((r_state == MEAS) && !w_timeout_evt) begin
            r_period_cnt <= sat_inc(r_period_cnt, 1'b1);
            r_f_low_cnt  <= sat_inc(r_f_low_cnt, ~f_in);
            r_g_high_cnt <= sat_inc(r_g_high_cnt, g_in);
        end
    end

`ifdef WAVE_MON_PHASE_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_phase_cnt  <= '0;
            r_phase_done <= 1'b0;
        end else if (w_reload) begin
            r_phase_cnt  <= 10'd1;
            r_phase_done <= w_rise_g;
        end else if ((r_state == MEAS) && !w_timeout_evt && !r_phase_done) begin
            // The rising-edge cycle itself is not counted; the count freezes.
            if (w_rise_g) r_phase_done <= 1'b1;
            else          r_phase_cnt  <= sat_inc(r_phase_cnt, 1'b1);
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Tolerance checks on the counts being published
    // -------------------------------------------------------------------------
    assign w_err_f = out_of_tol(r_f_low_cnt, EXP_F_LOW);
    assign w_err_g = out_of_tol(r_g_high_cnt, EXP_G_HIGH);
`ifdef WAVE_MON_PHASE_EN
    assign w_err_p = out_of_tol(r_period_cnt, EXP_PERIOD) | out_of_tol(r_phase_cnt, EXP_PHASE);
`else
    assign w_err_p = out_of_tol(r_period_cnt, EXP_PERIOD);
`endif
    assign w_any_err = w_err_f | w_err_g | w_err_p;

    // -------------------------------------------------------------------------
    // Result registers and handshake
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_meas_valid <= 1'b0;
            r_f_low_len  <= '0;
            r_g_high_len <= '0;
            r_period_len <= '0;
            r_err_f      <= 1'b0;
            r_err_g      <= 1'b0;
            r_err_p      <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef WAVE_MON_PHASE_EN
            r_phase_len  <= '0;
`endif
        end else begin
            if (w_publish && (!r_meas_valid || meas_ready)) begin
                // Slot is empty or is being emptied this cycle: take the new result.
                r_meas_valid <= 1'b1;
                r_f_low_len  <= r_f_low_cnt;
                r_g_high_len <= r_g_high_cnt;
                r_period_len <= r_period_cnt;
                r_err_f      <= w_err_f;
                r_err_g      <= w_err_g;
                r_err_p      <= w_err_p;
`ifdef WAVE_MON_PHASE_EN
                r_phase_len  <= r_phase_cnt;
`endif
            end else if (r_meas_valid && meas_ready) begin
                r_meas_valid <= 1'b0;
            end
            if (w_publish && r_meas_valid && !meas_ready) r_overrun <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Status: timeout and lock tracking (dropped results still count)
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_timeout    <= 1'b0;
            r_locked     <= 1'b0;
            r_last_clean <= 1'b0;
        end else if (w_timeout_evt) begin
            r_timeout    <= 1'b1;
            r_locked     <= 1'b0;
            r_last_clean <= 1'b0;
        end else if (w_publish) begin
            r_last_clean <= ~w_any_err;
            r_locked     <= r_last_clean & ~w_any_err;
        end
    end

    assign meas_valid = r_meas_valid;
    assign f_low_len  = r_f_low_len;
    assign g_high_len = r_g_high_len;
    assign period_len = r_period_len;
`ifdef WAVE_MON_PHASE_EN
    assign phase_len  = r_phase_len;
`else
    assign phase_len  = '0;
`endif
    assign err_f      = r_err_f;
    assign err_g      = r_err_g;
    assign err_p      = r_err_p;
    assign overrun    = r_overrun;
    assign timeout    = r_timeout;
    assign locked     = r_locked;

endmodule

// File: tb/tb_wave_timing_monitor.sv
// -----------------------------------------------------------------------------
// tb_wave_timing_monitor
//
// Drives f/g as a sequence of periods, each described by (f low length,
// g high length, g rise offset, period length). The reference model predicts
// each published result straight from those descriptors and applies the
// handshake, overrun, lock and timeout rules at transaction level. Every cycle
// the full output vector is compared with the model; directed checks cover
// the reference waveform, held results, coincident consume/publish, a
// stretched f-low, timeout and an asynchronous mid-period reset.
// -----------------------------------------------------------------------------
module tb_wave_timing_monitor;

    localparam int EXP_F_LOW  = 199;
    localparam int EXP_G_HIGH = 249;
    localparam int EXP_PERIOD = 901;
    localparam int TOL        = 0;
    localparam int EXP_PHASE  = 100;
    localparam int TMO_COUNT  = 1023;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       f_in = 1'b0;
    logic       g_in = 1'b0;
    logic       meas_ready = 1'b0;
    logic       meas_valid;
    logic [9:0] f_low_len, g_high_len, period_len, phase_len;
    logic       err_f, err_g, err_p, overrun, timeout, locked;

    wave_timing_monitor #(
        .EXP_F_LOW (EXP_F_LOW),
        .EXP_G_HIGH(EXP_G_HIGH),
        .EXP_PERIOD(EXP_PERIOD),
        .TOL       (TOL)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .f_in      (f_in),
        .g_in      (g_in),
        .meas_ready(meas_ready),
        .meas_valid(meas_valid),
        .f_low_len (f_low_len),
        .g_high_len(g_high_len),
        .period_len(period_len),
        .phase_len (phase_len),
        .err_f     (err_f),
        .err_g     (err_g),
        .err_p     (err_p),
        .overrun   (overrun),
        .timeout   (timeout),
        .locked    (locked)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    endtask

    // ---------------------------------------------------------------- model
    int drv_l, drv_h, drv_p;          // descriptor of the period being driven
    int cur_l, cur_h, cur_p;          // descriptor of the period being measured
    bit m_prev_f, m_meas;
    int m_cnt;                        // cycles elapsed in the measured period
    int m_streak;
    bit m_valid, m_err_f, m_err_g, m_err_p, m_overrun, m_timeout, m_locked;
    int m_f_len, m_g_len, m_p_len, m_ph_len;

    function automatic int absdiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    task automatic model_reset();
        m_prev_f = 0; m_meas = 0; m_cnt = 0; m_streak = 0;
        m_valid = 0; m_err_f = 0; m_err_g = 0; m_err_p = 0;
        m_overrun = 0; m_timeout = 0; m_locked = 0;
        m_f_len = 0; m_g_len = 0; m_p_len = 0; m_ph_len = 0;
    endtask

    task automatic model_edge(input bit f, input bit rdy);
        bit fall, pub, ef, eg, ep;
        int pf, pg, pp, pph;
        fall = m_prev_f && !f;
        m_prev_f = f;
        pub = 0; pf = 0; pg = 0; pp = 0; pph = 0;
        if (fall) begin
            if (m_meas) begin
                pub = 1; pf = cur_l; pg = cur_h; pp = m_cnt; pph = cur_p;
            end
            m_meas = 1; m_cnt = 1;
            cur_l = drv_l; cur_h = drv_h; cur_p = drv_p;
        end else if (m_meas) begin
            if (m_cnt + 1 >= TMO_COUNT) begin
                m_meas = 0; m_timeout = 1; m_locked = 0; m_streak = 0;
            end else begin
                m_cnt++;
            end
        end
        if (pub) begin
            ef = absdiff(pf, EXP_F_LOW) > TOL;
            eg = absdiff(pg, EXP_G_HIGH) > TOL;
            ep = absdiff(pp, EXP_PERIOD) > TOL;
`ifdef WAVE_MON_PHASE_EN
            ep = ep || (absdiff(pph, EXP_PHASE) > TOL);
`else
            pph = 0;
`endif
            if (!m_valid || rdy) begin
                m_valid = 1; m_f_len = pf; m_g_len = pg; m_p_len = pp; m_ph_len = pph;
                m_err_f = ef; m_err_g = eg; m_err_p = ep;
            end else begin
                m_overrun = 1;
            end
            if (ef || eg || ep) begin
                m_streak = 0; m_locked = 0;
            end else begin
                m_streak++;
                if (m_streak >= 2) m_locked = 1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
    endtask

    function automatic logic [63:0] exp_vec();
        return {17'd0, m_valid, 10'(m_f_len), 10'(m_g_len), 10'(m_p_len), 10'(m_ph_len),
                m_err_f, m_err_g, m_err_p, m_overrun, m_timeout, m_locked};
    endfunction

    function automatic logic [63:0] dut_vec();
        return {17'd0, meas_valid, f_low_len, g_high_len, period_len, phase_len,
                err_f, err_g, err_p, overrun, timeout, locked};
    endfunction

    // ---------------------------------------------------------------- drive
    task automatic step(input bit f, input bit g, input bit rdy);
        f_in = f; g_in = g; meas_ready = rdy;
        @(posedge clock);
        model_edge(f, rdy);
        #1;
        cyc++;
        check($sformatf("cyc%0d", cyc), dut_vec(), exp_vec());
    endtask

    // mode: 0 ready always, 1 never, 2 random, 3 only in the falling-edge cycle
    task automatic run_period(input int l, input int h, input int p, input int t,
                              input int mode, input int ncyc);
        bit r;
        drv_l = l; drv_h = h; drv_p = p;
        for (int o = 0; o < ncyc; o++) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = 1'b0;
                2:       r = ($urandom % 4) != 0;
                default: r = (o == 0);
            endcase
            step(o >= l, (o >= p) && (o < p + h), r);
        end
    endtask

    task automatic ref_period(input int mode);
        run_period(199, 249, 100, 901, mode, 901);
    endtask

    task automatic check_ref_result(input string tag);
        check({tag, "_f_low"},  f_low_len,  10'd199);
        check({tag, "_g_high"}, g_high_len, 10'd249);
        check({tag, "_period"}, period_len, 10'd901);
`ifdef WAVE_MON_PHASE_EN
        check({tag, "_phase"},  phase_len,  10'd100);
`else
        check({tag, "_phase"},  phase_len,  10'd0);
`endif
    endtask

    initial begin
        int t, l, p, h, mode;
        model_reset();
        drv_l = 0; drv_h = 0; drv_p = 0; cur_l = 0; cur_h = 0; cur_p = 0;

        // Reset state
        #12;
        check("reset_outputs", dut_vec(), 64'd0);
        @(negedge clock);
        resetn = 1'b1;
        repeat (5) step(1'b1, 1'b0, 1'b1);

        // Reference waveform, always ready
        repeat (3) ref_period(0);
        check("ref_locked", locked, 1'b1);
        check("ref_errs", {err_f, err_g, err_p}, 3'b000);
        check_ref_result("ref");

        // Consume coinciding with a publish
        repeat (2) ref_period(3);
        check("coincide_valid", meas_valid, 1'b1);
        check("coincide_overrun", overrun, 1'b0);

        // Held result while consumer stalls for two periods
        repeat (2) ref_period(1);
        check("stall_overrun", overrun, 1'b1);
        check("stall_valid", meas_valid, 1'b1);
        check("stall_locked", locked, 1'b1);
        check_ref_result("stall_held");
        ref_period(0);
        check_ref_result("stall_release");

        // Stretched f low in one period
        run_period(210, 249, 100, 901, 0, 901);
        ref_period(0);
        check("stretch_err_f", err_f, 1'b1);
        check("stretch_f_low", f_low_len, 10'd210);
        check("stretch_locked", locked, 1'b0);
        repeat (2) ref_period(0);
        check("relock", locked, 1'b1);

        // f stuck high: timeout, back to search, no publish
        repeat (1100) step(1'b1, 1'b0, 1'b1);
        check("tmo_timeout", timeout, 1'b1);
        check("tmo_locked", locked, 1'b0);
        check("tmo_no_publish", meas_valid, 1'b0);

        // Randomized periods
        for (int i = 0; i < 12; i++) begin
            mode = $urandom % 4;
            if ($urandom % 2) begin
                ref_period(mode);
            end else begin
                t = $urandom_range(300, 1000);
                l = $urandom_range(1, t - 1);
                p = $urandom_range(1, t - 1);
                h = $urandom_range(1, t - p);
                run_period(l, h, p, t, mode, t);
            end
        end

        // Asynchronous reset in the middle of a period
        run_period(199, 249, 100, 901, 0, 400);
        #2;
        resetn = 1'b0;
        #1;
        check("midreset_outputs", dut_vec(), 64'd0);
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        repeat (5) step(1'b1, 1'b0, 1'b1);
        ref_period(0);
        check("midreset_no_early_valid", meas_valid, 1'b0);
        repeat (2) ref_period(0);
        check("midreset_relock", locked, 1'b1);
        check_ref_result("midreset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
